// File: rtl/ratio_clk_ctrl.sv
// Sequencer for a ratio-driven clock divider: every ratio change lands on a divided-clock rise.
// Define RATIO_CTRL_TIMEOUT_EN to force a stalled change after TIMEOUT_CYC cycles without a rise.
module ratio_clk_ctrl #(
  parameter int RATIO_GRADE = 5,
  parameter int DWELL_W     = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   sweep_mode_i,
  input  logic [RATIO_GRADE-1:0] sweep_min_i,
  input  logic [RATIO_GRADE-1:0] sweep_max_i,
  input  logic [DWELL_W-1:0]     dwell_i,
  input  logic                   req_valid_i,
  input  logic [RATIO_GRADE-1:0] req_ratio_i,
  output logic                   req_ready_o,
  input  logic                   ratio_clk_i,
  output logic                   en_o,
  output logic [RATIO_GRADE-1:0] ratio_o,
  output logic                   busy_o,
  output logic                   step_done_o,
  output logic                   sweep_wrap_o,
  output logic                   timeout_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHANGE} state_t;

  state_t                 state;
  logic                   mode_q;
  logic [RATIO_GRADE-1:0] min_q;
  logic [RATIO_GRADE-1:0] max_q;
  logic [RATIO_GRADE-1:0] pending;
  logic [DWELL_W-1:0]     dwell_q;
  logic [DWELL_W-1:0]     dwell_cnt;
  logic                   clk_q;
  logic                   rise;
  logic                   tmo_hit;
  logic                   at_max;

  // Handshake: a request transfers on a clk_i edge where req_valid_i && req_ready_o.
  // Ready is offered only in RUN while in manual mode.
  assign req_ready_o = (state == S_RUN) && !mode_q;
  assign busy_o      = (state != S_IDLE);
  assign rise        = ratio_clk_i & ~clk_q;
  assign at_max      = (ratio_o >= max_q);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state        <= S_IDLE;
      mode_q       <= 1'b0;
      min_q        <= '0;
      max_q        <= '0;
      pending      <= '0;
      dwell_q      <= '0;
      dwell_cnt    <= '0;
      clk_q        <= 1'b0;
      en_o         <= 1'b0;
      ratio_o      <= '0;
      step_done_o  <= 1'b0;
      sweep_wrap_o <= 1'b0;
    end else begin
      step_done_o  <= 1'b0;
      sweep_wrap_o <= 1'b0;
      // Held low while disabled so the first high level after enable counts as a rise.
      clk_q        <= en_o & ratio_clk_i;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            mode_q    <= sweep_mode_i;
            min_q     <= sweep_min_i;
            max_q     <= sweep_max_i;
            dwell_q   <= (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
            dwell_cnt <= '0;
            en_o      <= 1'b1;
            if (sweep_mode_i) ratio_o <= sweep_min_i;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (stop_i) begin
            en_o  <= 1'b0;
            state <= S_IDLE;
          end else if (mode_q) begin
            if (tmo_hit || (rise && (dwell_cnt == dwell_q - 1'b1))) begin
              ratio_o      <= at_max ? min_q : ratio_o + 1'b1;
              sweep_wrap_o <= at_max;
              step_done_o  <= 1'b1;
              dwell_cnt    <= '0;
            end else if (rise) begin
              dwell_cnt <= dwell_cnt + 1'b1;
            end
          end else if (req_valid_i) begin
            pending <= req_ratio_i;
            state   <= S_CHANGE;
          end
        end
        S_CHANGE: begin
          if (stop_i) begin
            en_o  <= 1'b0;
            state <= S_IDLE;
          end else if (rise || tmo_hit) begin
            ratio_o     <= pending;
            step_done_o <= 1'b1;
            state       <= S_RUN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RATIO_CTRL_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_armed;

  // Armed while waiting on a pending manual change or between sweep rises.
  assign tmo_armed = (state == S_CHANGE) || ((state == S_RUN) && mode_q);
  assign tmo_hit   = tmo_armed && !rise && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      tmo_cnt   <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= tmo_hit && !stop_i;
      if (!tmo_armed || rise || tmo_hit) tmo_cnt <= '0;
      else                               tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  // TIMEOUT_CYC is always positive, so this ties timeout_o to 0.
  assign timeout_o = (TIMEOUT_CYC < 0);
`endif

endmodule
